// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared definitions for the pipeline hazard/stall controller.
//   REG_ZERO          : architectural register $0, which never causes a hazard
//   MD_CYCLES_DEFAULT : default busy time of the mult/div unit after issue
//   STALL_SAT_MAX     : value where the stall-cycle counter stops
//   md_state_e        : RUN when the mult/div unit is idle, MD_BUSY while it holds HI/LO
package hazard_pkg;

  localparam logic [4:0]  REG_ZERO          = 5'd0;
  localparam int          MD_CYCLES_DEFAULT = 32;
  localparam logic [31:0] STALL_SAT_MAX     = 32'hFFFF_FFFF;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if
// Bundles the signals between the pipeline and the hazard controller.
//   id_rs, id_rt            : source registers of the ID instruction
//   id_use_rs, id_use_rt    : the ID instruction really reads rs / rt
//   id_md_start             : the ID instruction is mult/multu/div/divu
//   id_hilo_use             : the ID instruction is mfhi/mflo/mthi/mtlo
//   ex_memread, ex_rt       : load in EX and its destination register
//   ex_branch_taken         : taken branch/jump resolved in EX
//   pc_write, ifid_write    : PC and IF/ID load enables
//   ifid_flush              : clear IF/ID to nop at the next edge
//   idex_stall              : bubble into ID/EX
//   md_issue, md_busy       : mult/div start pulse and busy flag
//   stall_cycles            : saturating count of stall (non-flush) cycles
// master = pipeline side, slave = hazard controller side.
interface hazard_ctrl_if;

  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_use_rs;
  logic        id_use_rt;
  logic        id_md_start;
  logic        id_hilo_use;
  logic        ex_memread;
  logic [4:0]  ex_rt;
  logic        ex_branch_taken;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_stall;
  logic        md_issue;
  logic        md_busy;
  logic [31:0] stall_cycles;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_md_start, id_hilo_use,
           ex_memread, ex_rt, ex_branch_taken,
    input  pc_write, ifid_write, ifid_flush, idex_stall, md_issue, md_busy,
           stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_md_start, id_hilo_use,
           ex_memread, ex_rt, ex_branch_taken,
    output pc_write, ifid_write, ifid_flush, idex_stall, md_issue, md_busy,
           stall_cycles
  );

endinterface

// File: rtl/md_timer.sv
// md_timer
// Load/decrement counter modelling how long the mult/div unit occupies HI/LO.
//   clk, rst : clock and asynchronous active-high reset
//   load     : start of a new mult/div; reloads the counter with MD_CYCLES
//   busy     : counter is non-zero, i.e. the unit is still working
module md_timer
  import hazard_pkg::*;
#(
  parameter int MD_CYCLES = MD_CYCLES_DEFAULT,
  parameter int CNT_W     = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic busy
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // A new issue always wins, so a back-to-back mult/div restarts the full period.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_W'(MD_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Decides each cycle whether the front of the pipeline holds, flushes or
// advances, and whether a bubble goes into ID/EX.
//   clk, rst : clock and asynchronous active-high reset
//   hif      : hazard_ctrl_if.slave carrying ID/EX hazard inputs and the
//              pc_write / ifid_write / ifid_flush / idex_stall / md_issue /
//              md_busy / stall_cycles outputs
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_CYCLES = MD_CYCLES_DEFAULT,
  parameter int CNT_W     = 6
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hif
);

  md_state_e   md_state;
  logic        md_busy;
  logic        load_use;
  logic        md_struct;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_stall;
  logic        md_issue;
  logic [31:0] stall_cycles_q;
  logic [31:0] stall_cycles_d;

  md_timer #(
    .MD_CYCLES (MD_CYCLES),
    .CNT_W     (CNT_W)
  ) u_md_timer (
    .clk  (clk),
    .rst  (rst),
    .load (md_issue),
    .busy (md_busy)
  );

  // Hazard decode. Priority is reset, then flush, then load-use/structural
  // hold. Reset forces a bubble with everything frozen, independent of inputs.
  // A wrong-path mult/div under a flush is dropped, so it never issues.
  always_comb begin
    md_state  = md_busy ? MD_BUSY : RUN;
    load_use  = hif.ex_memread && (hif.ex_rt != REG_ZERO) &&
                ((hif.id_use_rs && (hif.id_rs == hif.ex_rt)) ||
                 (hif.id_use_rt && (hif.id_rt == hif.ex_rt)));
    md_struct = (md_state == MD_BUSY) && (hif.id_hilo_use || hif.id_md_start);

    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_stall = 1'b0;
    md_issue   = 1'b0;

    if (rst) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_stall = 1'b1;
    end else if (hif.ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_stall = 1'b1;
    end else if (load_use || md_struct) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_stall = 1'b1;
    end else begin
      md_issue = hif.id_md_start;
    end
  end

  // Flush bubbles are not counted: only real hold cycles are interesting.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (idex_stall && !ifid_flush && (stall_cycles_q != STALL_SAT_MAX)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign hif.pc_write     = pc_write;
  assign hif.ifid_write   = ifid_write;
  assign hif.ifid_flush   = ifid_flush;
  assign hif.idex_stall   = idex_stall;
  assign hif.md_issue     = md_issue;
  assign hif.md_busy      = md_busy;
  assign hif.stall_cycles = stall_cycles_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the five-stage CPU. It sits beside the IF/ID and ID/EX pipeline registers and decides, each cycle, whether PC and IF/ID hold, whether IF/ID is flushed, and whether a bubble is injected into ID/EX through its `stall` input. It covers three cases: load-use hazards, a multi-cycle multiply/divide unit that occupies HI/LO, and taken branches resolved in EX.

## Interface
Parameters:
- `MD_CYCLES`, 32: cycles the mult/div unit is busy after issue (legal range 2..63).
- `CNT_W`, 6: width of the busy counter; must hold `MD_CYCLES`.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `id_rs`, `id_rt`  in  5 each  source register numbers of the instruction in ID.
- `id_use_rs`, `id_use_rt`  in  1 each  the ID instruction actually reads rs / rt.
- `id_md_start`  in  1  the ID instruction is mult/multu/div/divu.
- `id_hilo_use`  in  1  the ID instruction is mfhi/mflo/mthi/mtlo.
- `ex_memread`  in  1  the EX instruction is a load (ID/EX `MemRead_out`).
- `ex_rt`  in  5  the load destination in EX (ID/EX `rt_out`).
- `ex_branch_taken`  in  1  the branch or jump in EX is taken.
- `pc_write`  out  1  PC update enable.
- `ifid_write`  out  1  IF/ID load enable.
- `ifid_flush`  out  1  clear IF/ID to nop at the next edge.
- `idex_stall`  out  1  drives ID/EX `stall`, which zeroes the control fields and creates a bubble.
- `md_issue`  out  1  pulse that starts the mult/div unit.
- `md_busy`  out  1  the mult/div unit is occupied.
- `stall_cycles`  out  32  saturating count of cycles with `idex_stall`=1 and no flush.

## Operation
- State is `RUN` or `MD_BUSY`, held in the registered counter `md_cnt`. `MD_BUSY` holds exactly when `md_cnt`≠0.
- The hazard terms are combinational and evaluated in this priority order.
  - **Flush:** when `ex_branch_taken`=1, assert `ifid_flush`=1 and `idex_stall`=1, with `pc_write`=1 and `ifid_write`=1. `md_issue` stays 0 because the wrong-path mult/div is dropped. A load-use or busy condition in the same cycle is ignored.
  - **Load-use:** when `ex_memread`=1, `ex_rt`≠0, and either (`id_use_rs` and `id_rs`=`ex_rt`) or (`id_use_rt` and `id_rt`=`ex_rt`):
    - assert `pc_write`=0, `ifid_write`=0 and `idex_stall`=1;
    - this lasts exactly one cycle, because the bubble clears `ex_memread`.
  - **MD structural:** when `md_busy`=1 and (`id_hilo_use` or `id_md_start`), apply the same hold as load-use, repeated every cycle until `md_busy` falls.
  - **Otherwise:** `pc_write`=1, `ifid_write`=1, `ifid_flush`=0, `idex_stall`=0.
- `md_issue` = `id_md_start` and no flush and no stall in that cycle.
- Counter update on each rising edge:
  - `md_issue` → load `md_cnt` with `MD_CYCLES`;
  - else if `md_cnt`≠0 → decrement;
  - `md_busy` = (`md_cnt`≠0).
- `stall_cycles` increments on each edge where `idex_stall`=1 and `ifid_flush`=0. It saturates at 0xFFFFFFFF.
- Register $0 never creates a hazard.

## Timing
- While `rst`=1, asynchronously and independent of the inputs: `md_cnt`=0, `stall_cycles`=0, `md_busy`=0, `md_issue`=0, `pc_write`=0, `ifid_write`=0, `ifid_flush`=0, `idex_stall`=1.
- Reset asserted mid-operation aborts any mult/div busy period at once. The first edge after release is ordinary `RUN`.
- The hazard outputs are combinational from inputs and `md_cnt`, with zero latency, so they act at the same edge that would advance the pipeline.
- Issue at edge T gives `md_busy`=1 from T through T+`MD_CYCLES`−1. A mfhi that stalls is released in the cycle after `md_busy` falls.
- `id_md_start` in the last busy cycle is stalled. It issues the cycle after and reloads the counter.

## Structure
- Shared package `hazard_pkg` holds:
  - `REG_ZERO` = 5'd0;
  - default `MD_CYCLES`;
  - the `RUN`/`MD_BUSY` state enum;
  - the 32-bit saturate-max constant.
- Sub-module `md_timer`: a load/decrement counter with `load`, `busy`, and the `MD_CYCLES` parameter. Instantiated once.
- The hazard decode and `stall_cycles` stay in the top level.

## Test plan
- **Load-use:** `lw $5` in EX (`ex_memread`=1, `ex_rt`=5) and ID `add` with `id_rs`=5, `id_use_rs`=1 → one cycle of `pc_write`=0, `ifid_write`=0, `idex_stall`=1; `stall_cycles` 0→1; the next cycle is clean.
- **$0 and unused operand:**
  - `ex_rt`=0 with `id_rs`=0 → no stall;
  - `ex_rt`=7 with `id_rt`=7 and `id_use_rt`=0 → no stall.
- **MD busy:** `MD_CYCLES`=4; issue div at T, then mfhi in ID at T+1 → stalls during T+1..T+3, `md_busy` falls after T+3, mfhi proceeds at T+4; `stall_cycles`=3.
- **Flush priority:** `ex_branch_taken`=1 together with a load-use match and `id_md_start`=1 → `ifid_flush`=1, `idex_stall`=1, `pc_write`=1, `md_issue`=0; `stall_cycles` unchanged.
- **Reset mid-busy:** assert `rst` at cycle 2 of a 32-cycle div → `md_busy`=0 and `idex_stall`=1 immediately; after release, mfhi proceeds with no stall.
- **Saturation:** preload `stall_cycles` near 0xFFFFFFFE by force and hold a stall for 3 cycles → the counter stops at 0xFFFFFFFF.
